// File: rtl/teclado_pkg.sv
// Shared definitions for keypad consumers: function-key codes, the entry
// state machine encoding and the digit-count width helper.
package teclado_pkg;

    localparam logic [3:0] TECLA_CONFIRMA = 4'hA;
    localparam logic [3:0] TECLA_APAGA    = 4'hB;
    localparam logic [3:0] TECLA_LIMPA    = 4'hC;

    typedef enum logic {
        COLETA,
        PRONTO
    } estado_t;

    // Bits needed to hold a digit count from 0 up to n inclusive.
    function automatic int unsigned largura_contagem(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/detector_de_borda.sv
// Rising-edge detector for a key-valid level: one event per press,
// however long the decoder keeps the level high.
module detector_de_borda (
    input  logic clk,
    input  logic rst,
    input  logic sinal,
    output logic evento
);

    logic valido_q;
    logic valido_d;

    // Next value of the delayed level is simply the current level.
    always_comb begin
        valido_d = sinal;
    end

    // Delay the level by one cycle; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valido_q <= 1'b0;
        end else begin
            valido_q <= valido_d;
        end
    end

    // Event is high only in the first cycle the level is seen high.
    always_comb begin
        evento = sinal & ~valido_q;
    end

endmodule

// File: rtl/buffer_de_digitos.sv
// Multi-digit entry buffer fed by the keypad decoder. Collects up to
// N_DIGITOS BCD digits with backspace/clear/inactivity timeout, then holds
// the finished entry on a valid/ready handshake until it is taken.
module buffer_de_digitos
    import teclado_pkg::*;
#(
    parameter int unsigned N_DIGITOS      = 4,
    parameter int unsigned TIMEOUT_CICLOS = 1_000_000
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [3:0]                                tecla_value,
    input  logic                                      tecla_valid,
    input  logic                                      entrada_ready,
    output logic [4*N_DIGITOS-1:0]                    digitos,
    output logic [largura_contagem(N_DIGITOS)-1:0]    num_digitos,
    output logic                                      entrada_valid,
    output logic                                      erro,
    output logic                                      timeout
);

    localparam int unsigned LC = largura_contagem(N_DIGITOS);
    localparam int unsigned LT = $clog2(TIMEOUT_CICLOS);
    localparam int unsigned W  = 4 * N_DIGITOS;

    logic          evento;
    logic          eh_digito;

    estado_t       estado_q,  estado_d;
    logic [W-1:0]  digitos_q, digitos_d;
    logic [LC-1:0] num_q,     num_d;
    logic [LT-1:0] ocioso_q,  ocioso_d;
    logic          valid_q,   valid_d;
    logic          erro_q,    erro_d;
    logic          timeout_q, timeout_d;

    detector_de_borda u_borda (
        .clk    (clk),
        .rst    (rst),
        .sinal  (tecla_valid),
        .evento (evento)
    );

    // Key classification: codes 0-9 are digits.
    always_comb begin
        eh_digito = (tecla_value <= 4'd9);
    end

    // Next-state logic: key editing, idle timeout and handshake.
    always_comb begin
        estado_d  = estado_q;
        digitos_d = digitos_q;
        num_d     = num_q;
        ocioso_d  = ocioso_q;
        erro_d    = 1'b0;
        timeout_d = 1'b0;

        case (estado_q)
            COLETA: begin
                if (evento) begin
                    // Any key event restarts the idle window, even when it
                    // coincides with the cycle the timeout would fire.
                    ocioso_d = '0;
                    if (eh_digito) begin
                        if (num_q < LC'(N_DIGITOS)) begin
                            digitos_d = (digitos_q << 4) | W'(tecla_value);
                            num_d     = num_q + 1'b1;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end else if (tecla_value == TECLA_CONFIRMA) begin
                        if (num_q != '0) begin
                            estado_d = PRONTO;
                        end else begin
                            erro_d = 1'b1;
                        end
                    end else if (tecla_value == TECLA_APAGA) begin
                        if (num_q != '0) begin
                            digitos_d = digitos_q >> 4;
                            num_d     = num_q - 1'b1;
                        end
                    end else if (tecla_value == TECLA_LIMPA) begin
                        digitos_d = '0;
                        num_d     = '0;
                    end
                end else if (num_q == '0) begin
                    ocioso_d = '0;
                end else if (ocioso_q == LT'(TIMEOUT_CICLOS - 2)) begin
                    // Counter is about to reach TIMEOUT_CICLOS-1: discard now
                    // so the pulse lands TIMEOUT_CICLOS cycles after the key.
                    digitos_d = '0;
                    num_d     = '0;
                    ocioso_d  = '0;
                    timeout_d = 1'b1;
                end else begin
                    ocioso_d = ocioso_q + 1'b1;
                end
            end

            PRONTO: begin
                ocioso_d = '0;
                if (entrada_ready) begin
                    digitos_d = '0;
                    num_d     = '0;
                    estado_d  = COLETA;
                end
            end

            default: begin
                estado_d = COLETA;
            end
        endcase

        valid_d = (estado_d == PRONTO);
    end

    // State and registered outputs; synchronous reset aborts any entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= COLETA;
            digitos_q <= '0;
            num_q     <= '0;
            ocioso_q  <= '0;
            valid_q   <= 1'b0;
            erro_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            digitos_q <= digitos_d;
            num_q     <= num_d;
            ocioso_q  <= ocioso_d;
            valid_q   <= valid_d;
            erro_q    <= erro_d;
            timeout_q <= timeout_d;
        end
    end

    // Drive outputs straight from the flops.
    always_comb begin
        digitos       = digitos_q;
        num_digitos   = num_q;
        entrada_valid = valid_q;
        erro          = erro_q;
        timeout       = timeout_q;
    end

endmodule

// File: tb/tb_buffer_de_digitos.sv
// Scoreboard bench for buffer_de_digitos (N_DIGITOS=4, TIMEOUT_CICLOS=20).
module tb_buffer_de_digitos;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  tecla_value;
    logic        tecla_valid;
    logic        entrada_ready;
    logic [15:0] digitos;
    logic [2:0]  num_digitos;
    logic        entrada_valid;
    logic        erro;
    logic        timeout;

    typedef enum {NENHUM, ERRO, TIMEOUT_EV, ENTRADA} tipo_t;
    typedef struct {
        tipo_t       tipo;
        int          ciclo;
        logic [15:0] dig;
        int          num;
    } esperado_t;

    esperado_t fila[$];
    int checks = 0;
    int errors = 0;
    int ciclo = 0;
    int ult_evento = 0;
    logic valid_ant = 1'b0;

    buffer_de_digitos #(
        .N_DIGITOS      (4),
        .TIMEOUT_CICLOS (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tecla_value   (tecla_value),
        .tecla_valid   (tecla_valid),
        .entrada_ready (entrada_ready),
        .digitos       (digitos),
        .num_digitos   (num_digitos),
        .entrada_valid (entrada_valid),
        .erro          (erro),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic checar(input string nome, input logic [31:0] real_v, input logic [31:0] esp);
        checks++;
        if (real_v !== esp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, real_v, esp, ciclo);
        end
    endtask

    task automatic empurra(input tipo_t t, input int c, input logic [15:0] d, input int n);
        esperado_t e;
        e.tipo = t; e.ciclo = c; e.dig = d; e.num = n;
        fila.push_back(e);
    endtask

    task automatic consome(input tipo_t t);
        esperado_t e;
        checks++;
        if (fila.size() == 0) begin
            errors++;
            $display("FAIL monitor_%s: got unexpected pulse at cycle %0d expected none", t.name(), ciclo);
        end else begin
            e = fila.pop_front();
            if (e.tipo != t || e.ciclo != ciclo ||
                (t == ENTRADA && (e.dig !== digitos || e.num != int'(num_digitos)))) begin
                errors++;
                $display("FAIL monitor_%s: got %s cycle %0d dig %h num %0d expected %s cycle %0d dig %h num %0d",
                         t.name(), t.name(), ciclo, digitos, num_digitos,
                         e.tipo.name(), e.ciclo, e.dig, e.num);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    always @(negedge clk) begin
        if (erro)                        consome(ERRO);
        if (timeout)                     consome(TIMEOUT_EV);
        if (entrada_valid && !valid_ant) consome(ENTRADA);
        valid_ant = entrada_valid;
    end

    // Called at posedge+1; the next posedge is the event edge.
    task automatic pressiona(input logic [3:0] k, input int hold, input tipo_t t,
                             input logic [15:0] d, input int n);
        tecla_value = k;
        tecla_valid = 1'b1;
        @(posedge clk); #1;
        ult_evento = ciclo;
        if (t != NENHUM) empurra(t, ult_evento, d, n);
        repeat (hold - 1) begin
            @(posedge clk); #1;
        end
        tecla_valid = 1'b0;
        tecla_value = 4'hF;
        @(posedge clk); #1;
    endtask

    task automatic checa_vazio(input string nome);
        checar({nome, "_dig"},   32'(digitos),       32'h0);
        checar({nome, "_num"},   32'(num_digitos),   32'h0);
        checar({nome, "_valid"}, 32'(entrada_valid), 32'h0);
        checar({nome, "_erro"},  32'(erro),          32'h0);
        checar({nome, "_tmo"},   32'(timeout),       32'h0);
    endtask

    initial begin
        rst = 1'b1;
        tecla_value = 4'hF;
        tecla_valid = 1'b0;
        entrada_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checa_vazio("reset");
        rst = 1'b0;

        // 1,2,3,4 with long presses, then confirm and hand off
        for (int i = 1; i <= 4; i++) begin
            pressiona(4'(i), 7, NENHUM, 16'h0, 0);
            checar($sformatf("count_after_%0d", i), 32'(num_digitos), 32'(i));
        end
        checar("dig_1234", 32'(digitos), 32'h1234);
        pressiona(4'hA, 7, ENTRADA, 16'h1234, 4);
        repeat (3) @(posedge clk);
        #1;
        checar("valid_held", 32'(entrada_valid), 32'h1);
        checar("dig_frozen", 32'(digitos), 32'h1234);
        entrada_ready = 1'b1;
        @(posedge clk); #1;
        entrada_ready = 1'b0;
        checa_vazio("handoff");

        // overflow, backspace; ready high while collecting has no effect
        entrada_ready = 1'b1;
        pressiona(4'h5, 2, NENHUM, 16'h0, 0);
        pressiona(4'h6, 2, NENHUM, 16'h0, 0);
        pressiona(4'h7, 2, NENHUM, 16'h0, 0);
        pressiona(4'h8, 2, NENHUM, 16'h0, 0);
        pressiona(4'h9, 2, ERRO,   16'h0, 0);
        checar("dig_5678", 32'(digitos), 32'h5678);
        checar("num_full", 32'(num_digitos), 32'h4);
        pressiona(4'hB, 2, NENHUM, 16'h0, 0);
        checar("dig_bksp", 32'(digitos), 32'h0567);
        checar("num_bksp", 32'(num_digitos), 32'h3);
        checar("valid_ready_coleta", 32'(entrada_valid), 32'h0);
        entrada_ready = 1'b0;
        pressiona(4'hC, 2, NENHUM, 16'h0, 0);
        checar("dig_clr", 32'(digitos), 32'h0);

        // confirm on empty, clear after 1,2, backspace on empty, D/E/F silent
        pressiona(4'hA, 2, ERRO, 16'h0, 0);
        checar("valid_empty_a", 32'(entrada_valid), 32'h0);
        pressiona(4'h1, 2, NENHUM, 16'h0, 0);
        pressiona(4'h2, 2, NENHUM, 16'h0, 0);
        checar("dig_12", 32'(digitos), 32'h0012);
        pressiona(4'hD, 2, NENHUM, 16'h0, 0);
        pressiona(4'hE, 2, NENHUM, 16'h0, 0);
        checar("dig_ignored_def", 32'(digitos), 32'h0012);
        pressiona(4'hC, 2, NENHUM, 16'h0, 0);
        checar("dig_c", 32'(digitos), 32'h0);
        checar("num_c", 32'(num_digitos), 32'h0);
        pressiona(4'hB, 2, NENHUM, 16'h0, 0);
        checar("num_bksp_empty", 32'(num_digitos), 32'h0);

        // inactivity timeout 20 cycles after the key event
        pressiona(4'h3, 1, NENHUM, 16'h0, 0);
        empurra(TIMEOUT_EV, ult_evento + 19, 16'h0, 0);
        repeat (22) @(posedge clk);
        #1;
        checar("dig_tmo", 32'(digitos), 32'h0);
        checar("num_tmo", 32'(num_digitos), 32'h0);

        // a key landing on the timeout cycle wins
        pressiona(4'h3, 1, NENHUM, 16'h0, 0);
        repeat (17) @(posedge clk);
        #1;
        pressiona(4'h4, 1, NENHUM, 16'h0, 0);
        checar("dig_34", 32'(digitos), 32'h0034);
        checar("num_34", 32'(num_digitos), 32'h2);
        pressiona(4'hC, 1, NENHUM, 16'h0, 0);
        repeat (25) @(posedge clk);
        #1;
        checar("num_idle_empty", 32'(num_digitos), 32'h0);

        // keys ignored in PRONTO; a key held across handoff makes no event
        pressiona(4'h4, 2, NENHUM,  16'h0,    0);
        pressiona(4'h2, 2, NENHUM,  16'h0,    0);
        pressiona(4'hA, 2, ENTRADA, 16'h0042, 2);
        pressiona(4'h7, 2, NENHUM,  16'h0,    0);
        pressiona(4'hC, 2, NENHUM,  16'h0,    0);
        checar("dig_pronto", 32'(digitos), 32'h0042);
        checar("num_pronto", 32'(num_digitos), 32'h2);
        checar("valid_pronto", 32'(entrada_valid), 32'h1);
        tecla_value = 4'h5;
        tecla_valid = 1'b1;
        @(posedge clk); #1;
        entrada_ready = 1'b1;
        @(posedge clk); #1;
        entrada_ready = 1'b0;
        checa_vazio("handoff2");
        repeat (3) @(posedge clk);
        #1;
        tecla_valid = 1'b0;
        tecla_value = 4'hF;
        @(posedge clk); #1;
        checar("num_held_key", 32'(num_digitos), 32'h0);

        // reset in PRONTO and mid-entry
        pressiona(4'h9, 2, NENHUM,  16'h0,    0);
        pressiona(4'hA, 2, ENTRADA, 16'h0009, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checa_vazio("rst_pronto");
        pressiona(4'h1, 2, NENHUM, 16'h0, 0);
        pressiona(4'h2, 2, NENHUM, 16'h0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checa_vazio("rst_coleta");
        repeat (25) @(posedge clk);
        #1;

        checar("scoreboard_empty", 32'(fila.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_de_digitos.md
# buffer_de_digitos

Downstream consumer of the matrix-keypad decoder. Turns the decoder's `tecla_value`/`tecla_valid` stream into an edited multi-digit entry of up to `N_DIGITOS` decimal digits. Supports backspace, clear and inactivity timeout. Hands the finished entry to the next stage (password checker, display controller) over a valid/ready handshake.

## Interface
Parameters:
- `N_DIGITOS`, default 4: maximum digits held; range 1..8.
- `TIMEOUT_CICLOS`, default 1_000_000: idle cycles before a partial entry is discarded; at least 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `tecla_value`  in  4  key code from the decoder (0-9 digits, A-F function keys).
- `tecla_valid`  in  1  key-valid level from the decoder; may stay high for several cycles per press.
- `entrada_ready`  in  1  downstream accepts the entry.
- `digitos`  out  4*N_DIGITOS  packed BCD, newest digit in bits [3:0].
- `num_digitos`  out  $clog2(N_DIGITOS+1)  digits currently held.
- `entrada_valid`  out  1  entry complete and stable.
- `erro`  out  1  one-cycle pulse on a rejected key.
- `timeout`  out  1  one-cycle pulse when the entry is discarded by inactivity.

## Operation
- Key event: `evento = tecla_valid & ~valid_d`, where `valid_d` is `tecla_valid` registered. Exactly one event per press, regardless of pulse length.
- Key map while in COLETA:
  - 0-9, count < N: shift `digitos` left 4, insert key at [3:0], count +1.
  - 0-9, count == N: ignored, `erro` pulse.
  - A (confirm), count > 0: go to PRONTO.
  - A, count == 0: ignored, `erro` pulse.
  - B (backspace), count > 0: shift right 4, zero-fill the top nibble, count −1.
  - B, count == 0: no change, no `erro`.
  - C (clear): `digitos` = 0, count = 0.
  - D, E, F: ignored silently. 4'hF is also the decoder's idle code.
- States:
  - COLETA: editing. `entrada_valid` = 0. Idle counter runs while count > 0 and no event occurs. Any event reloads it to 0. When it reaches TIMEOUT_CICLOS−1: clear the buffer, pulse `timeout`, stay in COLETA. With count == 0 the counter is held at 0.
  - PRONTO: `entrada_valid` = 1; `digitos` and `num_digitos` frozen. All key events are ignored, with no `erro`. On `entrada_ready` = 1: clear the buffer, go to COLETA.
- Unused high nibbles of `digitos` are always 0.
- `valid_d` is updated in every state. A key held across the PRONTO→COLETA transition does not produce an event.

## Timing
- Reset values: `digitos` = 0, `num_digitos` = 0, `entrada_valid` = 0, `erro` = 0, `timeout` = 0, state COLETA, idle counter 0, `valid_d` = 0.
- Reset applied mid-entry or in PRONTO aborts everything on the next edge. Nothing is handed off.
- Digit, backspace or clear event in cycle t: new `digitos`/`num_digitos` visible in t+1.
- Confirm in cycle t: `entrada_valid` = 1 from t+1.
- Handshake completes on the edge where `entrada_valid & entrada_ready`. In t+1: `entrada_valid` = 0, buffer = 0.
- `entrada_ready` high while in COLETA has no effect.
- `erro`/`timeout` are registered, high exactly in the cycle after the cause.
- A timeout and an event in the same cycle: the event wins and the counter reloads.

## Structure
- Package `teclado_pkg`:
  - key constants `TECLA_CONFIRMA`=4'hA, `TECLA_APAGA`=4'hB, `TECLA_LIMPA`=4'hC;
  - state enum `{COLETA, PRONTO}`;
  - width helper for the count.
- Sub-module `detector_de_borda` produces `evento` from `tecla_valid`. It is reusable by other keypad consumers.
- The idle counter is $clog2(TIMEOUT_CICLOS) bits.

## Test plan
- Press 1,2,3,4 then A (N=4; each press holds `tecla_valid` for 7 cycles) → exactly 4 count increments; `digitos`=16'h1234, `num_digitos`=4, `entrada_valid`=1 until `entrada_ready`, then 0 and buffer 0.
- Press 5,6,7,8,9 (N=4) → `digitos`=16'h5678, one `erro` pulse on the 9; then B → 16'h0567, count 3.
- A with empty buffer → `erro` pulse, `entrada_valid` stays 0; C after 1,2 → `digitos`=0, count 0.
- TIMEOUT_CICLOS=20: press 3 then idle → `timeout` pulse 20 cycles after the event, buffer 0. Repeat with a press at cycle 19 → no timeout.
- Confirm 4,2, hold `entrada_ready`=0 and press 7 and C → `digitos`=16'h0042 unchanged, no `erro`; assert `entrada_ready` → clear next cycle.
- Assert `rst` during PRONTO and again mid-entry → all outputs at reset values the cycle after.
